// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - byte-serial 32-bit MIPS instruction fetch with decoded fields
//
// Purpose:
//   Reads one big-endian instruction as four bytes from an 8-bit instruction
//   memory, holds it in a committed register and exposes its decoded fields.
//   Partially received bytes live in a shadow buffer, so instr and its fields
//   stay stable until the whole instruction has arrived.
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When defined, a per-byte wait counter aborts a fetch after TIMEOUT_CYC
//   cycles without mem_rdata_valid. The abort restores pc to the start
//   address and pulses fetch_err. When undefined, FETCH waits forever and
//   fetch_err is tied low.
//
// Ports:
//   clock, reset                        clock (rising edge), async active-high reset
//   fetch_start, branch_en              requests, sampled only in IDLE
//   branch_target                       new pc on branch
//   mem_addr, mem_rd_en                 byte read request to instruction memory
//   mem_rdata, mem_rdata_valid          byte returned by memory
//   pc                                  current byte pc
//   instr                               last completed instruction
//   opcode, rs, rt, rd, funct, imm      decoded fields of instr
//   instr_valid                         1-cycle pulse on commit
//   busy                                high in FETCH and DONE
//   fetch_err                           1-cycle pulse on timeout abort
module instr_fetch_unit #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd_en,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_rdata_valid,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic            instr_valid,
  output logic            busy,
  output logic            fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [1:0]      byte_cnt;
  logic [31:0]     shadow;
  logic [PC_W-1:0] start_pc;
  logic            byte_ok;
  logic            last_byte;
  logic            timeout;

  assign byte_ok   = (state == S_FETCH) && mem_rdata_valid;
  assign last_byte = byte_ok && (byte_cnt == 2'd3);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fetch_start) state_next = S_FETCH;
      S_FETCH: begin
        if (last_byte) begin
          state_next = S_DONE;
        end else if (timeout) begin
          state_next = S_IDLE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_rd_en   = (state == S_FETCH);
    busy        = (state != S_IDLE);
    instr_valid = (state == S_DONE);
  end

  // Datapath: pc, byte counter, shadow buffer and committed instruction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      byte_cnt <= 2'd0;
      shadow   <= 32'd0;
      instr    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // A same-cycle branch redirects pc before the fetch starts from it.
          if (branch_en) pc <= branch_target;
          if (fetch_start) byte_cnt <= 2'd0;
        end
        S_FETCH: begin
          if (byte_ok) begin
            case (byte_cnt)
              2'd0:    shadow[31:24] <= mem_rdata;
              2'd1:    shadow[23:16] <= mem_rdata;
              2'd2:    shadow[15:8]  <= mem_rdata;
              default: shadow[7:0]   <= mem_rdata;
            endcase
            pc       <= pc + 1'b1;
            byte_cnt <= byte_cnt + 2'd1;
            // The final byte is merged directly so instr commits on the DONE entry edge.
            if (last_byte) instr <= {shadow[31:8], mem_rdata};
          end else if (timeout) begin
            pc <= start_pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WAIT_W-1:0] wait_cnt;

  // Timeout fires on the TIMEOUT_CYC-th consecutive FETCH cycle without a byte.
  assign timeout = (state == S_FETCH) && !mem_rdata_valid &&
                   (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_pc  <= RESET_PC;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= timeout;
      if (state == S_IDLE && fetch_start) begin
        start_pc <= branch_en ? branch_target : pc;
      end
      if (state != S_FETCH || mem_rdata_valid || timeout) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign start_pc  = pc;
  assign fetch_err = 1'b0;
`endif

  assign mem_addr = pc;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];

endmodule
